// File: rtl/omsp_sha512_periph_pkg.sv
// Shared definitions for the openMSP430 SHA-512 peripheral.
// Contents: FSM state encoding, register offsets, CTRL bit positions,
// frontend command codes and the number of 16-bit hash words read back.
package omsp_sha512_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_FINAL   = 2'd2,
    ST_READOUT = 2'd3
  } sha_state_e;

  localparam logic [1:0] REG_CTRL = 2'd0;  // W: CTRL, R: STATUS
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_HASH = 2'd2;
  localparam logic [1:0] REG_WCNT = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_FINISH  = 1;
  localparam int CTRL_ABORT   = 2;
  localparam int CTRL_CLR_OVR = 3;

  localparam logic [1:0] SHA_CMD_IDLE  = 2'b00;
  localparam logic [1:0] SHA_CMD_READ  = 2'b01;
  localparam logic [1:0] SHA_CMD_WRITE = 2'b10;

  localparam int         HASH_WORDS = 32;
  localparam logic [4:0] HASH_LAST  = 5'(HASH_WORDS - 1);

  // Idle cycles spent in FINAL before giving up on seeing busy rise.
  localparam logic [1:0] FIN_WAIT = 2'd1;

endpackage

// File: rtl/omsp_sha512_periph_wbuf.sv
// One-entry message word buffer between the CPU DATA register and the
// SHA-512 frontend.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           drop any pending word (START/ABORT)
//   clr_ovr_i         clear the sticky overrun flag
//   wr_i              DATA register write accepted by the FSM
//   wr_data_i/size_i  word and size of that write
//   first_i           first word since START: bypasses ready
//   ready_i           frontend ready_for_data
//   issue_o           word handed to the frontend this cycle
//   issue_data_o/size_o  the word being issued
//   pending_o         buffer slot occupied
//   overrun_o         a word was dropped because the slot was full
module omsp_sha512_periph_wbuf
  import omsp_sha512_periph_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        clr_ovr_i,
  input  logic        wr_i,
  input  logic [15:0] wr_data_i,
  input  logic        wr_size_i,
  input  logic        first_i,
  input  logic        ready_i,
  output logic        issue_o,
  output logic [15:0] issue_data_o,
  output logic        issue_size_o,
  output logic        pending_o,
  output logic        overrun_o
);

  logic        pend_q, pend_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        pend_size_q, pend_size_d;
  logic        ovr_q, ovr_d;

  always_comb begin
    issue_o      = 1'b0;
    issue_data_o = pend_data_q;
    issue_size_o = pend_size_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_size_d  = pend_size_q;
    ovr_d        = ovr_q;
    if (flush_i) begin
      pend_d = 1'b0;
    end else if (wr_i && (first_i || (ready_i && !pend_q))) begin
      issue_o      = 1'b1;
      issue_data_o = wr_data_i;
      issue_size_o = wr_size_i;
    end else if (wr_i && pend_q && ready_i) begin
      // Older word goes out first; the new one refills the slot.
      issue_o     = 1'b1;
      pend_data_d = wr_data_i;
      pend_size_d = wr_size_i;
    end else if (wr_i && !pend_q) begin
      pend_d      = 1'b1;
      pend_data_d = wr_data_i;
      pend_size_d = wr_size_i;
    end else if (wr_i) begin
      ovr_d = 1'b1;
    end else if (pend_q && ready_i) begin
      issue_o = 1'b1;
      pend_d  = 1'b0;
    end
    if (clr_ovr_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_data_q <= 16'h0000;
      pend_size_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_size_q <= pend_size_d;
      ovr_q       <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/omsp_sha512_periph.sv
// openMSP430 peripheral slave in front of the SHA-512 frontend.
// Turns CPU register accesses into the frontend cmd/data/data_size stream,
// sequences finalisation and reads the 32-word hash back.
// Optional build macro: SHA512_PERIPH_IRQ_EN adds the irq output and the
// irq_pend status bit.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   per_addr/din/en/we, per_dout  openMSP430 peripheral bus
//   sha_cmd, sha_data, sha_data_size  stream to the frontend
//   sha_hash, sha_busy, sha_ready_for_data  from the frontend
//   irq                         completion interrupt (IRQ_EN builds only)
//
// state   | meaning
// IDLE    | no operation in progress
// LOAD    | message words accepted from DATA writes
// FINAL   | drain buffer, hold read cmd until frontend finishes
// READOUT | each HASH read returns a word and advances the frontend
module omsp_sha512_periph
  import omsp_sha512_periph_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h0098,
  parameter int          DEC_WD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [1:0]  sha_cmd,
  output logic [15:0] sha_data,
  output logic        sha_data_size,
  input  logic [15:0] sha_hash,
  input  logic        sha_busy,
  input  logic        sha_ready_for_data
`ifdef SHA512_PERIPH_IRQ_EN
  ,
  output logic        irq
`endif
);

  sha_state_e  state_q;
  logic [1:0]  cmd_q;
  logic [15:0] stage_data_q, sha_data_q;
  logic        stage_size_q, sha_size_q;
  logic [15:0] wcnt_q;
  logic [4:0]  idx_q;
  logic        first_q;
  logic        busy_seen_q;
  logic [1:0]  fin_tmr_q;
  logic        irq_pend;

  logic              sel, rd, wr_any, ctrl_wr;
  logic [DEC_WD-1:0] reg_idx;
  logic              start, finish, abort, clr_ovr_cmd;
  logic              data_wr, hash_rd, readout_done;
  logic [15:0]       data_word;

  logic        buf_issue, buf_issue_size, buf_pending, buf_overrun;
  logic [15:0] buf_issue_data;

  assign sel     = per_en && (per_addr[13:DEC_WD] == BASE_ADDR[13:DEC_WD]);
  assign reg_idx = per_addr[DEC_WD-1:0];
  assign rd      = sel && (per_we == 2'b00);
  assign wr_any  = sel && (per_we != 2'b00);
  assign ctrl_wr = wr_any && (reg_idx == REG_CTRL) && per_we[0];

  assign abort       = ctrl_wr && per_din[CTRL_ABORT];
  assign start       = ctrl_wr && per_din[CTRL_START] && !abort && (state_q == ST_IDLE);
  assign finish      = ctrl_wr && per_din[CTRL_FINISH] && !abort && (state_q == ST_LOAD);
  assign clr_ovr_cmd = ctrl_wr && per_din[CTRL_CLR_OVR];

  // per_we=10 carries only the high byte, which has no meaning here.
  assign data_wr   = wr_any && (reg_idx == REG_DATA) && per_we[0] && (state_q == ST_LOAD);
  assign data_word = per_we[1] ? per_din : {8'h00, per_din[7:0]};

  assign hash_rd      = rd && (reg_idx == REG_HASH) && (state_q == ST_READOUT);
  assign readout_done = hash_rd && (idx_q == HASH_LAST);

  omsp_sha512_periph_wbuf u_wbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (abort || start),
    .clr_ovr_i    (clr_ovr_cmd || start),
    .wr_i         (data_wr),
    .wr_data_i    (data_word),
    .wr_size_i    (per_we[1]),
    .first_i      (first_q),
    .ready_i      (sha_ready_for_data),
    .issue_o      (buf_issue),
    .issue_data_o (buf_issue_data),
    .issue_size_o (buf_issue_size),
    .pending_o    (buf_pending),
    .overrun_o    (buf_overrun)
  );

  always_comb begin
    per_dout = 16'h0000;
    if (rd) begin
      case (reg_idx)
        REG_CTRL: per_dout = {10'b0, irq_pend, buf_overrun, buf_pending, sha_busy, state_q};
        REG_HASH: per_dout = (state_q == ST_READOUT) ? sha_hash : 16'h0000;
        REG_WCNT: per_dout = wcnt_q;
        default:  per_dout = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= SHA_CMD_IDLE;
      stage_data_q <= 16'h0000;
      stage_size_q <= 1'b0;
      sha_data_q   <= 16'h0000;
      sha_size_q   <= 1'b0;
      wcnt_q       <= 16'h0000;
      idx_q        <= 5'd0;
      first_q      <= 1'b0;
      busy_seen_q  <= 1'b0;
      fin_tmr_q    <= 2'd0;
    end else begin
      cmd_q <= SHA_CMD_IDLE;

      // The frontend samples data one cycle after the write command.
      if (buf_issue) begin
        stage_data_q <= buf_issue_data;
        stage_size_q <= buf_issue_size;
      end
      if (cmd_q == SHA_CMD_WRITE) begin
        sha_data_q <= stage_data_q;
        sha_size_q <= stage_size_q;
      end
      if (buf_issue && (wcnt_q != 16'hFFFF)) wcnt_q <= wcnt_q + 16'd1;

      if (abort) begin
        state_q <= ST_IDLE;
        first_q <= 1'b0;
        idx_q   <= 5'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_LOAD;
              first_q <= 1'b1;
              wcnt_q  <= 16'h0000;
              idx_q   <= 5'd0;
            end
          end
          ST_LOAD: begin
            if (buf_issue) begin
              cmd_q   <= SHA_CMD_WRITE;
              first_q <= 1'b0;
            end
            if (finish) begin
              state_q     <= ST_FINAL;
              busy_seen_q <= 1'b0;
              fin_tmr_q   <= FIN_WAIT;
            end
          end
          ST_FINAL: begin
            busy_seen_q <= busy_seen_q | sha_busy;
            if (buf_issue) begin
              cmd_q <= SHA_CMD_WRITE;
            end else if (!buf_pending) begin
              // Leave on a 1->0 busy edge, or after a short wait if busy never rose.
              if ((busy_seen_q && !sha_busy) ||
                  (!busy_seen_q && !sha_busy && (fin_tmr_q == 2'd0))) begin
                state_q <= ST_READOUT;
              end else begin
                cmd_q <= SHA_CMD_READ;
                if (!busy_seen_q && !sha_busy) fin_tmr_q <= fin_tmr_q - 2'd1;
              end
            end
          end
          ST_READOUT: begin
            if (hash_rd) begin
              cmd_q <= SHA_CMD_READ;
              idx_q <= idx_q + 5'd1;
              if (readout_done) state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SHA512_PERIPH_IRQ_EN
  logic irq_pend_q;
  logic status_rd;

  assign status_rd = rd && (reg_idx == REG_CTRL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= 1'b0;
    end else if (start) begin
      irq_pend_q <= 1'b0;
    end else if (readout_done && !abort) begin
      irq_pend_q <= 1'b1;
    end else if (status_rd) begin
      irq_pend_q <= 1'b0;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq      = irq_pend_q;
`else
  assign irq_pend = 1'b0;
`endif

  assign sha_cmd       = cmd_q;
  assign sha_data      = sha_data_q;
  assign sha_data_size = sha_size_q;

endmodule
